pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline sequencing controller for the in-order pipeline. It replaces the fixed five-enable operation controller. It tracks a valid bit per stage and generates the per-stage register load enables. It also handles load-use stalls, branch flushes, and program-end drain, and keeps retire and stall counters for the testbench and debug.

Parameters:
NUM_STAGES, 5, number of pipeline stages; stage 0 = fetch, stage NUM_STAGES-1 = writeback
HAZ_STAGE, 1, stage that raises a stall (decode)
BR_STAGE, 2, stage that resolves branches (execute); legal only if 0 <= HAZ_STAGE < BR_STAGE < NUM_STAGES
CNT_W, 16, width of the retire and stall counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
valid  input  1  an instruction is available to fetch this cycle
opr_finished  input  1  program end; no further fetches after this
hazard  input  1  load-use stall request from stage HAZ_STAGE
branch_taken  input  1  taken branch resolved in stage BR_STAGE
stage_en  output  NUM_STAGES  per-stage pipeline register load enable
stage_valid  output  NUM_STAGES  per-stage valid bits (registered)
flush  output  NUM_STAGES  per-stage squash, combinational
fetch_ready  output  1  fetch accepts the instruction this cycle
busy  output  1  state is RUN or DRAIN
done  output  1  pipeline drained after opr_finished
retired_cnt  output  CNT_W  count of valid instructions leaving writeback
stall_cnt  output  CNT_W  count of stall cycles

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; stage_valid=0; counters=0; done=0. All combinational outputs evaluate to 0.
- FSM states and transitions:
  - IDLE: opr_finished=1 goes to DONE. This wins over valid in the same cycle, and no fetch occurs. Otherwise valid=1 goes to RUN; that first instruction is not fetched in IDLE.
  - RUN: opr_finished=1 goes to DRAIN. A valid in the same cycle is not accepted.
  - DRAIN: when stage_valid==0 at a clock edge, go to DONE.
  - DONE: done=1 and sticky. valid=1 with opr_finished=0 goes to RUN and clears both counters on that edge.
- stall = busy & hazard & stage_valid[HAZ_STAGE]. hazard is ignored when stage HAZ_STAGE holds no valid instruction.
- brk = busy & branch_taken & stage_valid[BR_STAGE]. When brk=1, stall is forced to 0: flush has priority.
- flush[i] = brk for i < BR_STAGE, otherwise 0.
- stage_en[i] = busy & !(stall & i <= HAZ_STAGE).
- fetch_ready = (state==RUN) & !stall & !opr_finished.
- Valid update on each edge while busy:
  - brk: v[i]=0 for i <= BR_STAGE-1, except that v[0] still captures a new fetch (valid & fetch_ready); v[BR_STAGE]=v[BR_STAGE-1]=0; later stages shift.
  - Stated precisely: v[BR_STAGE]<=0 (the squashed instruction from stage BR_STAGE-1 does not advance). v[i], 0<i<BR_STAGE, <=0. v[0]<=valid&fetch_ready. v[i]<=v[i-1] for i>BR_STAGE.
  - stall: v[i] hold for i <= HAZ_STAGE; v[HAZ_STAGE+1]<=0 (bubble); v[i]<=v[i-1] for i > HAZ_STAGE+1.
  - otherwise: v[0]<=valid&fetch_ready; v[i]<=v[i-1].
- Latency: an instruction accepted at edge k gives v[0]=1 after edge k. With no stall or flush, v[NUM_STAGES-1]=1 after edge k+NUM_STAGES-1.
- retired_cnt: +1 at each edge where busy & v[NUM_STAGES-1]=1; saturates at all-ones.
- stall_cnt: +1 at each edge where stall=1; saturates at all-ones.
- Stall and flush are both honoured in DRAIN. A drain with a pending stall completes once the bubble propagates.
- Reset mid-operation: all state is cleared immediately, without a clock edge.

Test Plan:
- Defaults; valid=1 for 6 accepting edges, then an opr_finished pulse -> retired_cnt=6, stall_cnt=0. done rises 5 edges after the last accept. busy=0 when done=1.
- hazard=1 for 2 cycles while v[1]=1 -> stage_en[1:0]=0 for exactly 2 cycles; v[2]=0 for 2 consecutive cycles; stall_cnt=2; a final retire count of N loses no instruction.
- branch_taken=1 with v[2:0]=3'b111 -> flush=5'b00011 in that cycle. Next cycle v[2:1]=0 and v[0]=valid. Of 8 accepted instructions, retired_cnt=6.
- hazard and branch_taken in the same cycle with v[2:1]=2'b11 -> stall_cnt unchanged, flush=5'b00011, stage_en=5'b11111.
- reset driven low mid-RUN between clock edges -> stage_valid, done, busy, retired_cnt and stall_cnt read 0 before the next edge. After release, the block is in IDLE.
- CNT_W=4, 20 instructions run to completion -> retired_cnt=4'hF (saturated), done=1. A subsequent valid restarts with counters cleared to 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline sequencing controller.
// Tracks one valid bit per stage, generates per-stage load enables and squash
// strobes, handles load-use stalls, taken-branch flushes and end-of-program
// drain, and keeps saturating retire/stall counters.
// Parameter legality: 0 <= HAZ_STAGE < BR_STAGE < NUM_STAGES.
module pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int HAZ_STAGE  = 1,
  parameter int BR_STAGE   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  opr_finished,
  input  logic                  hazard,
  input  logic                  branch_taken,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  fetch_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [NUM_STAGES-1:0] v_nxt;
  logic [NUM_STAGES-1:0] shift_in;
  logic                  stall;
  logic                  brk;
  logic                  fetch_acc;
  logic                  cnt_clr;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  // Hazard/branch qualification and per-stage enables; a flush overrides a stall.
  always_comb begin
    busy        = (state == RUN) || (state == DRAIN);
    done        = (state == DONE);
    brk         = busy & branch_taken & stage_valid[BR_STAGE];
    stall       = busy & hazard & stage_valid[HAZ_STAGE] & ~brk;
    fetch_ready = (state == RUN) & ~stall & ~opr_finished;
    fetch_acc   = valid & fetch_ready;
    stage_en    = '0;
    flush       = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_en[i] = busy & ~(stall & (i <= HAZ_STAGE));
      flush[i]    = brk & (i < BR_STAGE);
    end
  end

  // Next valid vector: plain shift, stall (hold front, inject bubble) or flush.
  always_comb begin
    shift_in = {stage_valid[NUM_STAGES-2:0], fetch_acc};
    v_nxt    = stage_valid;
    if (busy) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (brk) begin
          // Younger stages are squashed; stage 0 may still take a new fetch.
          if (i == 0)             v_nxt[i] = fetch_acc;
          else if (i <= BR_STAGE) v_nxt[i] = 1'b0;
          else                    v_nxt[i] = shift_in[i];
        end else if (stall) begin
          if (i <= HAZ_STAGE)          v_nxt[i] = stage_valid[i];
          else if (i == HAZ_STAGE + 1) v_nxt[i] = 1'b0;
          else                         v_nxt[i] = shift_in[i];
        end else begin
          v_nxt[i] = shift_in[i];
        end
      end
    end
  end

  // Sequencing FSM next state; drain completes on the edge that empties the pipe.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (opr_finished)  state_nxt = DONE;
        else if (valid)    state_nxt = RUN;
      end
      RUN: begin
        if (opr_finished)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (v_nxt == '0)   state_nxt = DONE;
      end
      DONE: begin
        if (valid && !opr_finished) begin
          state_nxt = RUN;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Per-stage valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stage_valid <= '0;
    else        stage_valid <= v_nxt;
  end

  // Retire and stall counters, cleared when a finished run restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else if (cnt_clr) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (busy && stage_valid[NUM_STAGES-1]) retired_cnt <= sat_inc(retired_cnt);
      if (stall)                             stall_cnt   <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scenario tasks for pipe_ctrl with a retire-timing scoreboard.
module tb_pipe_ctrl;

  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic          opr_finished;
  logic          hazard;
  logic          branch_taken;
  logic [NS-1:0] stage_en, stage_valid, flush;
  logic          fetch_ready, busy, done;
  logic [15:0]   retired_cnt, stall_cnt;
  logic [NS-1:0] d4_stage_en, d4_stage_valid, d4_flush;
  logic          d4_fetch_ready, d4_busy, d4_done;
  logic [3:0]    d4_retired_cnt, d4_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  bit sb_on    = 1'b0;
  int exp_q[$];

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .valid(valid), .opr_finished(opr_finished),
    .hazard(hazard), .branch_taken(branch_taken), .stage_en(stage_en),
    .stage_valid(stage_valid), .flush(flush), .fetch_ready(fetch_ready),
    .busy(busy), .done(done), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .valid(valid), .opr_finished(opr_finished),
    .hazard(hazard), .branch_taken(branch_taken), .stage_en(d4_stage_en),
    .stage_valid(d4_stage_valid), .flush(d4_flush), .fetch_ready(d4_fetch_ready),
    .busy(d4_busy), .done(d4_done), .retired_cnt(d4_retired_cnt), .stall_cnt(d4_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Scoreboard: an accept at edge k must retire at edge k+NS (no stall/flush runs).
  always @(negedge clk) begin
    #2;
    if (reset && sb_on) begin
      if (valid && fetch_ready) exp_q.push_back(edge_n + 1 + NS);
      if (busy && stage_valid[NS-1]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_retire: unexpected retire at edge %0d, none outstanding", edge_n + 1);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (e != edge_n + 1) begin
            n_fail++;
            $display("FAIL sb_retire: retired at edge %0d, expected edge %0d", edge_n + 1, e);
          end
        end
      end
    end
  end

  task automatic start_run();
    valid = 1'b1; opr_finished = 1'b0; hazard = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(output int cyc);
    opr_finished = 1'b1; hazard = 1'b0; branch_taken = 1'b0;
    cyc = 0;
    @(negedge clk);
    cyc = 1; opr_finished = 1'b0; valid = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 1'b1; opr_finished = 1'b0; hazard = 1'b1; branch_taken = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (stage_valid !== 5'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 00000", stage_valid); end
    n_checks++; if ({busy, done, fetch_ready} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {busy, done, fetch_ready}); end
    n_checks++; if ({stage_en, flush} !== 10'b0) begin n_fail++; $display("FAIL rst_en_flush: got %b want 0", {stage_en, flush}); end
    n_checks++; if ({retired_cnt, stall_cnt} !== 32'b0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", {retired_cnt, stall_cnt}); end
    @(negedge clk);
    valid = 1'b0; hazard = 1'b0; branch_taken = 1'b0; reset = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    exp_q.delete(); sb_on = 1'b1;
    start_run();
    #1;
    n_checks++; if ({busy, fetch_ready} !== 2'b11) begin n_fail++; $display("FAIL basic_run: busy/fetch_ready got %b want 11", {busy, fetch_ready}); end
    n_checks++; if (stage_valid !== 5'b0) begin n_fail++; $display("FAIL basic_idle_nofetch: got %b want 00000", stage_valid); end
    repeat (6) @(negedge clk);
    drain(cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL basic_done_lat: got %0d want 5", cyc); end
    n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL basic_done_busy: got %b want 10", {done, busy}); end
    n_checks++; if (retired_cnt !== 16'd6) begin n_fail++; $display("FAIL basic_retired: got %0d want 6", retired_cnt); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_stall: got %0d want 0", stall_cnt); end
    sb_on = 1'b0;
  endtask

  task automatic test_stall();
    int cyc;
    start_run();
    n_checks++; if ({retired_cnt, stall_cnt} !== 32'b0) begin n_fail++; $display("FAIL stall_restart_clr: got %h want 0", {retired_cnt, stall_cnt}); end
    repeat (3) @(negedge clk);
    hazard = 1'b1; #1;
    n_checks++; if (stage_en !== 5'b11100) begin n_fail++; $display("FAIL stall_en1: got %b want 11100", stage_en); end
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL stall_fetch: got %b want 0", fetch_ready); end
    @(negedge clk); #1;
    n_checks++; if (stage_valid !== 5'b01011) begin n_fail++; $display("FAIL stall_v1: got %b want 01011", stage_valid); end
    n_checks++; if (stage_en !== 5'b11100) begin n_fail++; $display("FAIL stall_en2: got %b want 11100", stage_en); end
    @(negedge clk);
    hazard = 1'b0; #1;
    n_checks++; if (stage_valid !== 5'b10011) begin n_fail++; $display("FAIL stall_v2: got %b want 10011", stage_valid); end
    n_checks++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL stall_en3: got %b want 11111", stage_en); end
    n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d want 2", stall_cnt); end
    repeat (3) @(negedge clk);
    drain(cyc);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_drain_timeout: done got %b want 1", done); end
    n_checks++; if (retired_cnt !== 16'd6) begin n_fail++; $display("FAIL stall_retired: got %0d want 6", retired_cnt); end
  endtask

  task automatic test_branch();
    int cyc;
    start_run();
    repeat (3) @(negedge clk);
    branch_taken = 1'b1; #1;
    n_checks++; if (flush !== 5'b00011) begin n_fail++; $display("FAIL br_flush: got %b want 00011", flush); end
    n_checks++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL br_en: got %b want 11111", stage_en); end
    @(negedge clk);
    branch_taken = 1'b0; #1;
    n_checks++; if (stage_valid !== 5'b01001) begin n_fail++; $display("FAIL br_v: got %b want 01001", stage_valid); end
    n_checks++; if (flush !== 5'b00000) begin n_fail++; $display("FAIL br_flush_off: got %b want 00000", flush); end
    repeat (4) @(negedge clk);
    drain(cyc);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL br_drain_timeout: done got %b want 1", done); end
    n_checks++; if (retired_cnt !== 16'd6) begin n_fail++; $display("FAIL br_retired: got %0d want 6", retired_cnt); end
  endtask

  task automatic test_haz_br();
    int cyc;
    start_run();
    repeat (3) @(negedge clk);
    hazard = 1'b1; branch_taken = 1'b1; #1;
    n_checks++; if (flush !== 5'b00011) begin n_fail++; $display("FAIL hb_flush: got %b want 00011", flush); end
    n_checks++; if (stage_en !== 5'b11111) begin n_fail++; $display("FAIL hb_en: got %b want 11111", stage_en); end
    @(negedge clk);
    hazard = 1'b0; branch_taken = 1'b0; #1;
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL hb_stall_cnt: got %0d want 0", stall_cnt); end
    n_checks++; if (stage_valid !== 5'b01001) begin n_fail++; $display("FAIL hb_v: got %b want 01001", stage_valid); end
    drain(cyc);
    n_checks++; if (retired_cnt !== 16'd2) begin n_fail++; $display("FAIL hb_retired: got %0d want 2", retired_cnt); end
  endtask

  task automatic test_reset_mid();
    start_run();
    repeat (6) @(negedge clk);
    hazard = 1'b1;
    @(negedge clk);
    hazard = 1'b0; #1;
    n_checks++; if ({retired_cnt, stall_cnt} !== {16'd2, 16'd1}) begin n_fail++; $display("FAIL rm_pre_cnt: got %h want 00020001", {retired_cnt, stall_cnt}); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({stage_valid, done, busy} !== 7'b0) begin n_fail++; $display("FAIL rm_state: got %b want 0", {stage_valid, done, busy}); end
    n_checks++; if ({retired_cnt, stall_cnt} !== 32'b0) begin n_fail++; $display("FAIL rm_cnt: got %h want 0", {retired_cnt, stall_cnt}); end
    @(negedge clk);
    valid = 1'b0; reset = 1'b1; #1;
    n_checks++; if ({busy, done, stage_valid} !== 7'b0) begin n_fail++; $display("FAIL rm_release: got %b want 0", {busy, done, stage_valid}); end
    // From IDLE, opr_finished beats valid and goes straight to DONE.
    valid = 1'b1; opr_finished = 1'b1;
    @(negedge clk); #1;
    n_checks++; if ({done, busy, stage_valid} !== 7'b1000000) begin n_fail++; $display("FAIL idle_finish: got %b want 1000000", {done, busy, stage_valid}); end
    valid = 1'b0; opr_finished = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int cyc;
    exp_q.delete(); sb_on = 1'b1;
    start_run();
    n_checks++; if (d4_retired_cnt !== 4'h0) begin n_fail++; $display("FAIL sat_start: got %h want 0", d4_retired_cnt); end
    repeat (20) @(negedge clk);
    drain(cyc);
    n_checks++; if (d4_done !== 1'b1) begin n_fail++; $display("FAIL sat_done: got %b want 1", d4_done); end
    n_checks++; if (d4_retired_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_retired4: got %h want f", d4_retired_cnt); end
    n_checks++; if (retired_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_retired16: got %0d want 20", retired_cnt); end
    sb_on = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d outstanding want 0", exp_q.size()); end
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; #1;
    n_checks++; if ({d4_retired_cnt, d4_stall_cnt} !== 8'h00) begin n_fail++; $display("FAIL sat_restart_clr: got %h want 00", {d4_retired_cnt, d4_stall_cnt}); end
    n_checks++; if (d4_busy !== 1'b1) begin n_fail++; $display("FAIL sat_restart_busy: got %b want 1", d4_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_haz_br();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
